// File: rtl/snake_move_sequencer_if.sv
// Body RAM port of the snake move sequencer.
// Synchronous read: mem_rdata is valid one cycle after mem_addr is presented with mem_we low.
interface snake_move_sequencer_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 10
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_we,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/snake_move_sequencer.sv
// Runs one snake move per game step over the circular body RAM.
// Each step computes the next head, checks walls and body, then commits the new head and length.
module snake_move_sequencer #(
  parameter int unsigned X_W        = 5,
  parameter int unsigned Y_W        = 5,
  parameter int unsigned GRID_W     = 32,
  parameter int unsigned GRID_H     = 24,
  parameter int unsigned MAX_LEN    = 64,
  parameter int unsigned STEP_TICKS = 250,
  parameter int unsigned INIT_LEN   = 3
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         tick,
  input  logic                         clear,
  input  logic                         run,
  input  logic [2:0]                   dir,
  input  logic [X_W-1:0]               food_x,
  input  logic [Y_W-1:0]               food_y,
  snake_move_sequencer_if.master       mem,
  output logic [X_W-1:0]               head_x,
  output logic [Y_W-1:0]               head_y,
  output logic [$clog2(MAX_LEN):0]     length,
  output logic                         busy,
  output logic                         ate,
  output logic                         step_done,
  output logic                         lose
);

  localparam int unsigned AW     = $clog2(MAX_LEN);
  localparam int unsigned LW     = AW + 1;
  localparam int unsigned CW     = $clog2(STEP_TICKS);
  localparam int unsigned InitX0 = GRID_W / 2 - (INIT_LEN - 1);

  localparam logic [2:0] DirRight = 3'd1;
  localparam logic [2:0] DirLeft  = 3'd2;
  localparam logic [2:0] DirUp    = 3'd3;
  localparam logic [2:0] DirDown  = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StWait,
    StCalc,
    StScan,
    StWrite,
    StDone,
    StDead
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0]  head_ptr_q;
  logic [LW-1:0]  length_q;
  logic [LW-1:0]  last_q;
  logic [LW-1:0]  idx_q;
  logic [CW-1:0]  count_q;
  logic [X_W-1:0] head_x_q, next_x_q, calc_x;
  logic [Y_W-1:0] head_y_q, next_y_q, calc_y;
  logic           eat_q;
  logic           rd_valid_q;
  logic           busy_q;
  logic           ate_q;
  logic           step_done_q;
  logic           lose_q;

  logic dir_valid;
  logic count_en;
  logic expiry;
  logic wall;
  logic calc_eat;
  logic hit;
  logic scan_end;

  assign dir_valid = (dir != 3'd0);
  assign count_en  = tick && run && dir_valid;
  assign expiry    = count_en && (count_q == CW'(STEP_TICKS - 1));
  assign calc_eat  = (calc_x == food_x) && (calc_y == food_y);
  // rd_valid_q marks that mem_rdata carries the segment read issued last cycle.
  assign hit       = rd_valid_q && (mem.mem_rdata == {next_x_q, next_y_q});
  assign scan_end  = (idx_q == last_q + LW'(1));

  // Candidate next head and wall test, evaluated from the live dir during CALC.
  always_comb begin
    calc_x = head_x_q;
    calc_y = head_y_q;
    wall   = 1'b0;
    unique case (dir)
      DirRight: begin
        if (head_x_q == X_W'(GRID_W - 1)) wall = 1'b1;
        else                              calc_x = head_x_q + X_W'(1);
      end
      DirLeft: begin
        if (head_x_q == '0) wall = 1'b1;
        else                calc_x = head_x_q - X_W'(1);
      end
      DirUp: begin
        if (head_y_q == '0) wall = 1'b1;
        else                calc_y = head_y_q - Y_W'(1);
      end
      DirDown: begin
        if (head_y_q == Y_W'(GRID_H - 1)) wall = 1'b1;
        else                              calc_y = head_y_q + Y_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StIdle;
      StInit:  if (idx_q == LW'(INIT_LEN - 1)) state_d = StWait;
      StWait:  if (expiry) state_d = StCalc;
      StCalc:  state_d = wall ? StDead : StScan;
      StScan: begin
        if (hit)           state_d = StDead;
        else if (scan_end) state_d = StWrite;
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StWait;
      StDead:  state_d = StDead;
      default: state_d = StIdle;
    endcase
    if (clear) state_d = StInit;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      head_ptr_q  <= '0;
      length_q    <= '0;
      last_q      <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      head_x_q    <= '0;
      head_y_q    <= '0;
      next_x_q    <= '0;
      next_y_q    <= '0;
      eat_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      ate_q       <= 1'b0;
      step_done_q <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= !(state_d inside {StIdle, StWait, StDead});
      ate_q       <= 1'b0;
      step_done_q <= 1'b0;

      if (clear) begin
        count_q <= '0;
      end else if (count_en) begin
        count_q <= expiry ? '0 : count_q + CW'(1);
      end

      if (clear) begin
        idx_q      <= '0;
        rd_valid_q <= 1'b0;
        lose_q     <= 1'b0;
      end else begin
        unique case (state_q)
          StInit: begin
            idx_q <= idx_q + LW'(1);
            if (state_d == StWait) begin
              head_ptr_q <= AW'(INIT_LEN - 1);
              length_q   <= LW'(INIT_LEN);
              head_x_q   <= X_W'(GRID_W / 2);
              head_y_q   <= Y_W'(GRID_H / 2);
            end
          end
          StCalc: begin
            next_x_q   <= calc_x;
            next_y_q   <= calc_y;
            eat_q      <= calc_eat;
            // A growing snake keeps its tail, so the tail cell stays an obstacle.
            last_q     <= calc_eat ? length_q - LW'(1) : length_q - LW'(2);
            idx_q      <= '0;
            rd_valid_q <= 1'b0;
            if (wall) lose_q <= 1'b1;
          end
          StScan: begin
            rd_valid_q <= (idx_q <= last_q);
            idx_q      <= idx_q + LW'(1);
            if (hit) lose_q <= 1'b1;
          end
          StWrite: begin
            head_ptr_q  <= head_ptr_q + AW'(1);
            head_x_q    <= next_x_q;
            head_y_q    <= next_y_q;
            if (eat_q && (length_q < LW'(MAX_LEN))) length_q <= length_q + LW'(1);
            ate_q       <= eat_q;
            step_done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mem.mem_we    = 1'b0;
    mem.mem_addr  = head_ptr_q - AW'(idx_q);
    mem.mem_wdata = {next_x_q, next_y_q};
    unique case (state_q)
      StInit: begin
        mem.mem_we    = 1'b1;
        mem.mem_addr  = AW'(idx_q);
        mem.mem_wdata = {X_W'(InitX0) + X_W'(idx_q), Y_W'(GRID_H / 2)};
      end
      StWrite: begin
        mem.mem_we   = 1'b1;
        mem.mem_addr = head_ptr_q + AW'(1);
      end
      default: ;
    endcase
  end

  assign head_x    = head_x_q;
  assign head_y    = head_y_q;
  assign length    = length_q;
  assign busy      = busy_q;
  assign ate       = ate_q;
  assign step_done = step_done_q;
  assign lose      = lose_q;

endmodule

// File: tb/tb_snake_move_sequencer.sv
// Bench for snake_move_sequencer: scripted scenarios plus a random walk,
// checked against a queue-based model of the snake body.
module tb_snake_move_sequencer;

  localparam int unsigned X_W        = 5;
  localparam int unsigned Y_W        = 5;
  localparam int unsigned GRID_W     = 32;
  localparam int unsigned GRID_H     = 24;
  localparam int unsigned MAX_LEN    = 64;
  localparam int unsigned STEP_TICKS = 250;
  localparam int unsigned INIT_LEN   = 3;
  localparam int unsigned AW         = 6;

  logic           clock   = 1'b0;
  logic           reset_n = 1'b0;
  logic           tick    = 1'b0;
  logic           clear   = 1'b0;
  logic           run     = 1'b0;
  logic [2:0]     dir     = 3'd0;
  logic [X_W-1:0] food_x  = '0;
  logic [Y_W-1:0] food_y  = '0;
  logic [X_W-1:0] head_x;
  logic [Y_W-1:0] head_y;
  logic [AW:0]    length;
  logic           busy, ate, step_done, lose;

  snake_move_sequencer_if #(.ADDR_W(AW), .DATA_W(X_W + Y_W)) mem_bus ();

  snake_move_sequencer #(
    .X_W(X_W), .Y_W(Y_W), .GRID_W(GRID_W), .GRID_H(GRID_H),
    .MAX_LEN(MAX_LEN), .STEP_TICKS(STEP_TICKS), .INIT_LEN(INIT_LEN)
  ) dut (
    .clock(clock), .reset_n(reset_n), .tick(tick), .clear(clear), .run(run), .dir(dir),
    .food_x(food_x), .food_y(food_y), .mem(mem_bus.master),
    .head_x(head_x), .head_y(head_y), .length(length),
    .busy(busy), .ate(ate), .step_done(step_done), .lose(lose)
  );

  always #5 clock = ~clock;

  logic [X_W+Y_W-1:0] ram [MAX_LEN];
  always @(posedge clock) begin
    if (mem_bus.mem_we) ram[mem_bus.mem_addr] <= mem_bus.mem_wdata;
    mem_bus.mem_rdata <= ram[mem_bus.mem_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  int wr_addr_q[$];
  int wr_data_q[$];
  int n_done = 0, n_ate = 0, n_ate_alone = 0, n_busy = 0;

  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_bus.mem_we) begin
        wr_addr_q.push_back(int'(mem_bus.mem_addr));
        wr_data_q.push_back(int'(mem_bus.mem_wdata));
      end
      if (step_done) n_done++;
      if (ate) n_ate++;
      if (ate && !step_done) n_ate_alone++;
      if (busy) n_busy++;
    end
  end

  // Body model: index k of the queues is segment k (0 = head).
  int mx[$], my[$];
  int m_len, m_hp;

  function automatic void model_init();
    mx.delete();
    my.delete();
    for (int k = 0; k < int'(INIT_LEN); k++) begin
      mx.push_back(int'(GRID_W) / 2 - k);
      my.push_back(int'(GRID_H) / 2);
    end
    m_len = INIT_LEN;
    m_hp  = INIT_LEN - 1;
  endfunction

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      tick = 1'b1;
    end
    @(negedge clock);
    tick = 1'b0;
  endtask

  task automatic wait_not_busy(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clock);
    repeat (2) @(negedge clock);
  endtask

  task automatic do_init();
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    wait_not_busy(20);
    model_init();
  endtask

  task automatic run_step(input int d, input int fx, input int fy, input int nticks,
                          input bit drop_run, input string tag, output bit died);
    int  nx, ny, last, exp_len, done0, ate0, busy0;
    bit  eat, dead;
    nx = mx[0];
    ny = my[0];
    case (d)
      1: nx++;
      2: nx--;
      3: ny--;
      4: ny++;
      default: ;
    endcase
    dead = (nx < 0) || (nx >= int'(GRID_W)) || (ny < 0) || (ny >= int'(GRID_H));
    eat  = (nx == fx) && (ny == fy);
    last = eat ? m_len - 1 : m_len - 2;
    if (!dead) for (int k = 0; k <= last; k++) if (mx[k] == nx && my[k] == ny) dead = 1'b1;
    exp_len = (eat && m_len < int'(MAX_LEN)) ? m_len + 1 : m_len;

    dir    = 3'(d);
    food_x = X_W'(fx);
    food_y = Y_W'(fy);
    run    = 1'b1;
    wr_addr_q.delete();
    wr_data_q.delete();
    done0 = n_done;
    ate0  = n_ate;
    busy0 = n_busy;
    tick_n(nticks);
    if (drop_run) run = 1'b0;
    for (int i = 0; i < 200 && n_done == done0 && !lose; i++) @(negedge clock);
    repeat (3) @(negedge clock);

    if (dead) begin
      n_vec++;
      if (lose !== 1'b1 || n_done != done0 || wr_addr_q.size() != 0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL %s death: lose=%b steps=%0d writes=%0d busy=%b, want lose=1 steps=0 writes=0 busy=0",
                 tag, lose, n_done - done0, wr_addr_q.size(), busy);
      end
    end else begin
      n_vec++;
      if (lose !== 1'b0 || n_done - done0 != 1) begin
        n_err++;
        $display("FAIL %s commit: lose=%b steps=%0d, want lose=0 steps=1", tag, lose, n_done - done0);
      end
      n_vec++;
      if (wr_addr_q.size() != 1 || wr_addr_q[0] != (m_hp + 1) % int'(MAX_LEN) ||
          wr_data_q[0] != ((nx << Y_W) | ny)) begin
        n_err++;
        $display("FAIL %s write: count=%0d addr=%0d data=%0h, want 1 write addr=%0d data=%0h", tag,
                 wr_addr_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[0] : -1,
                 (wr_data_q.size() > 0) ? wr_data_q[0] : -1, (m_hp + 1) % int'(MAX_LEN),
                 (nx << Y_W) | ny);
      end
      n_vec++;
      if (int'(head_x) != nx || int'(head_y) != ny || int'(length) != exp_len) begin
        n_err++;
        $display("FAIL %s head: got (%0d,%0d) len %0d, want (%0d,%0d) len %0d", tag, head_x, head_y,
                 length, nx, ny, exp_len);
      end
      n_vec++;
      if (n_ate - ate0 != int'(eat) || n_ate_alone != 0) begin
        n_err++;
        $display("FAIL %s ate: pulses=%0d stray=%0d, want pulses=%0d stray=0", tag, n_ate - ate0,
                 n_ate_alone, eat);
      end
      n_vec++;
      if (n_busy - busy0 != last + 5) begin
        n_err++;
        $display("FAIL %s busy cycles: got %0d, want %0d", tag, n_busy - busy0, last + 5);
      end
      mx.push_front(nx);
      my.push_front(ny);
      if (exp_len == m_len) begin
        void'(mx.pop_back());
        void'(my.pop_back());
      end
      m_len = exp_len;
      m_hp  = (m_hp + 1) % int'(MAX_LEN);
    end
    died = dead;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_vec++;
    if (head_x !== '0 || head_y !== '0 || length !== '0) begin
      n_err++;
      $display("FAIL reset head/len: got (%0d,%0d) len %0d, want 0", head_x, head_y, length);
    end
    n_vec++;
    if ({busy, ate, step_done, lose, mem_bus.mem_we} !== 5'b0) begin
      n_err++;
      $display("FAIL reset flags: busy/ate/done/lose/we=%b, want 00000",
               {busy, ate, step_done, lose, mem_bus.mem_we});
    end
    reset_n = 1'b1;
    run = 1'b1;
    dir = 3'd1;
    tick_n(STEP_TICKS + 5);
    n_vec++;
    if (wr_addr_q.size() != 0 || busy !== 1'b0 || n_done != 0) begin
      n_err++;
      $display("FAIL idle hold: writes=%0d busy=%b steps=%0d, want 0 0 0", wr_addr_q.size(), busy,
               n_done);
    end
    run = 1'b0;
  endtask

  task automatic test_init();
    do_init();
    n_vec++;
    if (wr_addr_q.size() != int'(INIT_LEN)) begin
      n_err++;
      $display("FAIL init write count: got %0d, want %0d", wr_addr_q.size(), INIT_LEN);
    end else begin
      for (int k = 0; k < int'(INIT_LEN); k++) begin
        n_vec++;
        if (wr_addr_q[k] != k || wr_data_q[k] != (((14 + k) << Y_W) | 12)) begin
          n_err++;
          $display("FAIL init write %0d: addr=%0d data=%0h, want addr=%0d data=%0h", k,
                   wr_addr_q[k], wr_data_q[k], k, ((14 + k) << Y_W) | 12);
        end
      end
    end
    n_vec++;
    if (head_x !== 5'd16 || head_y !== 5'd12 || length !== 7'd3 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL init state: head (%0d,%0d) len %0d busy %b, want (16,12) len 3 busy 0", head_x,
               head_y, length, busy);
    end
  endtask

  task automatic test_move();
    bit died;
    int done0;
    dir    = 3'd1;
    run    = 1'b1;
    food_x = '0;
    food_y = '0;
    done0  = n_done;
    wr_addr_q.delete();
    tick_n(STEP_TICKS - 1);
    repeat (20) @(negedge clock);
    n_vec++;
    if (n_done != done0 || wr_addr_q.size() != 0) begin
      n_err++;
      $display("FAIL move early: steps=%0d writes=%0d after %0d ticks, want 0 0", n_done - done0,
               wr_addr_q.size(), STEP_TICKS - 1);
    end
    run_step(1, 0, 0, 1, 1'b0, "move", died);
  endtask

  task automatic test_eat();
    bit died;
    int done0;
    run   = 1'b0;
    done0 = n_done;
    tick_n(300);
    run = 1'b1;
    tick_n(STEP_TICKS - 1);
    repeat (10) @(negedge clock);
    n_vec++;
    if (n_done != done0) begin
      n_err++;
      $display("FAIL run hold: steps=%0d, want 0", n_done - done0);
    end
    run_step(1, 18, 12, 1, 1'b0, "eat", died);
  endtask

  task automatic test_tail_and_collision();
    bit died;
    run_step(4, 0, 0, STEP_TICKS, 1'b0, "coil down", died);
    run_step(2, 0, 0, STEP_TICKS, 1'b0, "coil left", died);
    run_step(3, 0, 0, STEP_TICKS, 1'b0, "into tail", died);
    run_step(2, 16, 12, STEP_TICKS, 1'b0, "grow to 5", died);
    run_step(4, 0, 0, STEP_TICKS, 1'b0, "coil down 2", died);
    run_step(1, 0, 0, STEP_TICKS, 1'b0, "hit seg3", died);
    n_vec++;
    if (!died || lose !== 1'b1) begin
      n_err++;
      $display("FAIL self collision: model died=%b lose=%b, want 1 1", died, lose);
    end
  endtask

  task automatic test_wall();
    bit died;
    int done0;
    do_init();
    for (int i = 0; i < 15; i++) run_step(1, 0, 0, STEP_TICKS, 1'b0, "to wall", died);
    run_step(1, 0, 0, STEP_TICKS, 1'b0, "wall", died);
    wr_addr_q.delete();
    done0 = n_done;
    tick_n(2 * STEP_TICKS + 10);
    n_vec++;
    if (lose !== 1'b1 || wr_addr_q.size() != 0 || n_done != done0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL dead hold: lose=%b writes=%0d steps=%0d busy=%b, want 1 0 0 0", lose,
               wr_addr_q.size(), n_done - done0, busy);
    end
    do_init();
    n_vec++;
    if (lose !== 1'b0 || wr_addr_q.size() != int'(INIT_LEN) || length !== 7'd3) begin
      n_err++;
      $display("FAIL reinit: lose=%b writes=%0d len=%0d, want 0 3 3", lose, wr_addr_q.size(), length);
    end
  endtask

  task automatic test_mid_clear();
    bit died;
    int done0;
    dir    = 3'd1;
    run    = 1'b1;
    food_x = '0;
    food_y = '0;
    done0  = n_done;
    tick_n(STEP_TICKS);
    @(negedge clock);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid-step busy: got %b, want 1", busy);
    end
    wr_addr_q.delete();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    wait_not_busy(20);
    model_init();
    n_vec++;
    if (wr_addr_q.size() != int'(INIT_LEN) || n_done != done0 || lose !== 1'b0 ||
        head_x !== 5'd16 || head_y !== 5'd12 || length !== 7'd3) begin
      n_err++;
      $display("FAIL mid clear: writes=%0d steps=%0d lose=%b head (%0d,%0d) len %0d, want 3 0 0 (16,12) 3",
               wr_addr_q.size(), n_done - done0, lose, head_x, head_y, length);
    end
    dir = 3'd0;
    tick_n(300);
    dir = 3'd1;
    tick_n(STEP_TICKS - 1);
    repeat (10) @(negedge clock);
    n_vec++;
    if (n_done != done0) begin
      n_err++;
      $display("FAIL dir none hold: steps=%0d, want 0", n_done - done0);
    end
    run_step(1, 0, 0, 1, 1'b0, "after dir none", died);
  endtask

  task automatic test_random();
    bit died;
    int d, nx, ny, fx, fy;
    do_init();
    for (int i = 0; i < 24; i++) begin
      d  = $urandom_range(1, 4);
      nx = mx[0] + ((d == 1) ? 1 : (d == 2) ? -1 : 0);
      ny = my[0] + ((d == 4) ? 1 : (d == 3) ? -1 : 0);
      if ($urandom_range(0, 1) == 1 && nx >= 0 && nx < int'(GRID_W) && ny >= 0 &&
          ny < int'(GRID_H)) begin
        fx = nx;
        fy = ny;
      end else begin
        fx = $urandom_range(0, GRID_W - 1);
        fy = $urandom_range(0, GRID_H - 1);
      end
      run_step(d, fx, fy, STEP_TICKS, 1'($urandom_range(0, 1)), "random", died);
      if (died) do_init();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_init();
    test_move();
    test_eat();
    test_tail_and_collision();
    test_wall();
    test_mid_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
